// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multicycle RV32I control sequencer with memory handshakes,
//            timeout-to-halt, single-step pause and cycle/retire counters.
// Revision : 1.0
// ============================================================================
module cpu_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_mode,
    input  logic             step,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             mem_access,
    input  logic             halt_req,
    input  logic             reg_write_en,
    output logic [2:0]       state,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             pc_en,
    output logic             wb_en,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_EXECUTE = 3'b011,
        S_MEMORY  = 3'b100,
        S_WRITE   = 3'b101,
        S_PAUSE   = 3'b110,
        S_HALT    = 3'b111
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_d;
    logic            err_set;
    logic            active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt    <= '0;
            bus_err     <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (err_set) begin
                bus_err <= 1'b1;
            end
            if (active) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (state_q == S_WRITE) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // wait_cnt is only meaningful inside fetch/memory; every path into
    // those states passes through a branch that zeroes it.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_cnt;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (run_en) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_cnt == TO_LIMIT) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end else begin
                    wait_d = wait_cnt + TO_W'(1);
                end
            end
            S_DECODE: begin
                state_d = halt_req ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                wait_d  = '0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!mem_access || dmem_ack) begin
                    state_d = S_WRITE;
                end else if (wait_cnt == TO_LIMIT) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end else begin
                    wait_d = wait_cnt + TO_W'(1);
                end
            end
            S_WRITE: begin
                wait_d = '0;
                if (step_mode) begin
                    state_d = S_PAUSE;
                end else if (!run_en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE: begin
                wait_d = '0;
                if (step || !step_mode) begin
                    state_d = run_en ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_comb begin
        active = 1'b0;
        case (state_q)
            S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITE: active = 1'b1;
            default:                                         active = 1'b0;
        endcase
    end

    assign state  = state_q;
    assign if_en  = (state_q == S_FETCH);
    assign id_en  = (state_q == S_DECODE);
    assign exe_en = (state_q == S_EXECUTE) || (state_q == S_MEMORY) || (state_q == S_WRITE);
    assign mem_en = (state_q == S_MEMORY) || (state_q == S_WRITE);
    assign pc_en  = (state_q == S_WRITE);
    assign wb_en  = (state_q == S_WRITE) && reg_write_en;
    assign halted = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed self-checking bench for cpu_sequencer (TIMEOUT=4).
// Revision : 1.0
// ============================================================================
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst, run_en, step_mode, step, imem_ack, dmem_ack;
    logic mem_access, halt_req, reg_write_en;

    logic [2:0]  state;
    logic        if_en, id_en, exe_en, mem_en, pc_en, wb_en, halted, bus_err;
    logic [15:0] cycle_cnt, retired_cnt;

    logic [2:0]  w_state;
    logic        w_if_en, w_id_en, w_exe_en, w_mem_en, w_pc_en, w_wb_en, w_halted, w_bus_err;
    logic [3:0]  w_cycle_cnt, w_retired_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(16), .TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .step_mode(step_mode), .step(step),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mem_access(mem_access),
        .halt_req(halt_req), .reg_write_en(reg_write_en),
        .state(state), .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en),
        .pc_en(pc_en), .wb_en(wb_en), .halted(halted), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap checks.
    cpu_sequencer #(.CNT_W(4), .TIMEOUT(4), .TO_W(3)) dut_w (
        .clk(clk), .rst(rst), .run_en(run_en), .step_mode(step_mode), .step(step),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mem_access(mem_access),
        .halt_req(halt_req), .reg_write_en(reg_write_en),
        .state(w_state), .if_en(w_if_en), .id_en(w_id_en), .exe_en(w_exe_en), .mem_en(w_mem_en),
        .pc_en(w_pc_en), .wb_en(w_wb_en), .halted(w_halted), .bus_err(w_bus_err),
        .cycle_cnt(w_cycle_cnt), .retired_cnt(w_retired_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; run_en = 1'b0; step_mode = 1'b0; step = 1'b0;
        imem_ack = 1'b1; dmem_ack = 1'b1; mem_access = 1'b0;
        halt_req = 1'b0; reg_write_en = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] en_exp [5];
        int pulses, wbp, fc, mc, wr_at, bad;
        en_exp[0] = 6'b100000; en_exp[1] = 6'b010000; en_exp[2] = 6'b001000;
        en_exp[3] = 6'b001100; en_exp[4] = 6'b001111;

        // Reset state
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({if_en, id_en, exe_en, mem_en, pc_en, wb_en, halted, bus_err}), 32'd0);
        check("rst_cnts", 32'({cycle_cnt, retired_cnt}), 32'd0);

        // Zero-wait free run
        run_en = 1'b1;
        tick();
        pulses = 0; wbp = 0;
        for (int i = 0; i < 20; i++) begin
            check("zw_state", 32'(state), 32'(1 + i % 5));
            check("zw_en", 32'({if_en, id_en, exe_en, mem_en, pc_en, wb_en}), 32'(en_exp[i % 5]));
            if (pc_en) pulses++;
            if (wb_en) wbp++;
            tick();
        end
        check("zw_cycle", 32'(cycle_cnt), 32'd20);
        check("zw_retired", 32'(retired_cnt), 32'd4);
        check("zw_pc_pulses", 32'(pulses), 32'd4);
        check("zw_wb_pulses", 32'(wbp), 32'd4);
        run_en = 1'b0;
        ticks(5);
        check("zw_stop_state", 32'(state), 32'd0);
        check("zw_stop_cnts", 32'({cycle_cnt, retired_cnt}), {16'd25, 16'd5});
        ticks(3);
        check("idle_no_count", 32'(cycle_cnt), 32'd25);

        // Wait states: ack on 4th fetch and 3rd memory cycle, no rd write
        do_reset();
        imem_ack = 1'b0; dmem_ack = 1'b0; mem_access = 1'b1; reg_write_en = 1'b0;
        run_en = 1'b1;
        tick();
        run_en = 1'b0;
        fc = 0; mc = 0; pulses = 0; wbp = 0; wr_at = -1;
        for (int k = 0; k < 15; k++) begin
            if (state == 3'd1) begin imem_ack = (fc == 3); fc++; end else imem_ack = 1'b0;
            if (state == 3'd4) begin dmem_ack = (mc == 2); mc++; end else dmem_ack = 1'b0;
            if (pc_en) begin pulses++; wr_at = k; end
            if (wb_en) wbp++;
            tick();
        end
        check("ws_write_at", 32'(wr_at), 32'd9);
        check("ws_pc_pulses", 32'(pulses), 32'd1);
        check("ws_wb_pulses", 32'(wbp), 32'd0);
        check("ws_bus_err", 32'(bus_err), 32'd0);
        check("ws_end_state", 32'(state), 32'd0);
        check("ws_cycle", 32'(cycle_cnt), 32'd10);

        // Fetch timeout: no ack ever
        do_reset();
        imem_ack = 1'b0; run_en = 1'b1;
        tick();
        fc = 0;
        while (state == 3'd1 && fc < 20) begin fc++; tick(); end
        check("to_fetch_cycles", 32'(fc), 32'd5);
        check("to_state", 32'(state), 32'd7);
        check("to_flags", 32'({halted, bus_err}), 32'b11);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            run_en = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            step = 1'($urandom); step_mode = 1'($urandom); halt_req = 1'($urandom);
            if (state != 3'd7 || !bus_err || !halted || pc_en) bad++;
            tick();
        end
        check("to_sticky", 32'(bad), 32'd0);
        check("to_cycle_frozen", 32'(cycle_cnt), 32'd5);

        // Ack on the last permitted fetch cycle, then memory timeout
        do_reset();
        imem_ack = 1'b0; run_en = 1'b1;
        tick();
        fc = 0;
        while (state == 3'd1 && fc < 20) begin imem_ack = (fc == 4); fc++; tick(); end
        check("late_ack_cycles", 32'(fc), 32'd5);
        check("late_ack_state", 32'(state), 32'd2);
        check("late_ack_err", 32'(bus_err), 32'd0);
        mem_access = 1'b1; dmem_ack = 1'b0;
        ticks(2);
        mc = 0;
        while (state == 3'd4 && mc < 20) begin mc++; tick(); end
        check("mto_cycles", 32'(mc), 32'd5);
        check("mto_state", 32'(state), 32'd7);
        check("mto_err_ret", 32'({bus_err, retired_cnt}), {16'd1, 16'd0});

        // Halt request in decode
        do_reset();
        run_en = 1'b1;
        tick();
        ticks(5);
        halt_req = 1'b1;
        tick();
        check("hr_decode", 32'(state), 32'd2);
        tick();
        check("hr_halt", 32'(state), 32'd7);
        check("hr_flags", 32'({halted, bus_err, pc_en}), 32'b100);
        check("hr_retired", 32'(retired_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; halt_req = 1'b0;
        check("hr_rst_state", 32'(state), 32'd0);
        check("hr_rst_cnts", 32'({cycle_cnt, retired_cnt}), 32'd0);

        // Single step
        do_reset();
        step_mode = 1'b1; run_en = 1'b1;
        tick();
        ticks(5);
        check("ss_pause", 32'(state), 32'd6);
        ticks(3);
        check("ss_hold", 32'(state), 32'd6);
        check("ss_cnts", 32'({cycle_cnt, retired_cnt}), {16'd5, 16'd1});
        step = 1'b1;
        tick();
        step = 1'b0;
        check("ss_step_fetch", 32'(state), 32'd1);
        ticks(5);
        check("ss_pause2", 32'(state), 32'd6);
        check("ss_retired2", 32'(retired_cnt), 32'd2);
        step_mode = 1'b0;
        tick();
        check("ss_resume", 32'(state), 32'd1);

        // Reset while waiting in memory
        do_reset();
        mem_access = 1'b1; dmem_ack = 1'b0; run_en = 1'b1;
        ticks(5);
        check("rm_in_mem", 32'(state), 32'd4);
        rst = 1'b1;
        tick();
        check("rm_state", 32'(state), 32'd0);
        check("rm_pc_wb", 32'({pc_en, wb_en, bus_err}), 32'd0);
        check("rm_cnts", 32'({cycle_cnt, retired_cnt}), 32'd0);
        rst = 1'b0;

        // Counter wrap on the 4-bit instance
        do_reset();
        run_en = 1'b1;
        tick();
        ticks(75);
        check("wrap_ret15", 32'(w_retired_cnt), 32'd15);
        check("wrap_cyc75", 32'(w_cycle_cnt), 32'd11);
        ticks(5);
        check("wrap_ret0", 32'(w_retired_cnt), 32'd0);
        check("wrap_cyc0", 32'(w_cycle_cnt), 32'd0);
        check("wide_ret16", 32'(retired_cnt), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
